// File: rtl/pga_chain_interface.sv
// Serial loader for a daisy chain of PGAs: shifts all channel gain codes out in one
// cs_n frame with a divided serial clock, a one-deep pending request and a cs_n idle gap.
//
// state    | meaning
// IDLE     | no frame, waiting for set_i
// SHIFT_LO | cs_n low, sclk_o low, miso presenting current bit
// SHIFT_HI | cs_n low, sclk_o high, PGAs capture current bit
// TAIL     | cs_n low, sclk_o low, hold after the last bit
// GAP      | cs_n high, guaranteed idle time before next frame
module pga_chain_interface #(
  parameter int CODE_W   = 8,
  parameter int N_CH     = 2,
  parameter int DIV_HALF = 1,
  parameter int CS_GAP   = 2
) (
  input  logic                     sck,
  input  logic                     rst,
  input  logic [N_CH*CODE_W-1:0]   codes_i,
  input  logic                     set_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     sclk_o,
  output logic                     cs_n,
  output logic                     miso
);

  localparam int NB      = N_CH * CODE_W;
  localparam int CNT_MAX = (DIV_HALF > CS_GAP) ? DIV_HALF : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(NB + 1);

  localparam logic [CNT_W-1:0] H_LOAD   = CNT_W'(DIV_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(NB - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, TAIL, GAP} state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [NB-1:0]    shreg, shreg_nxt;
  logic [NB-1:0]    pbuf, pbuf_nxt;
  logic             pend, pend_nxt;
  logic             in_frame;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    pbuf_nxt  = pbuf;
    pend_nxt  = pend;

    // Requests while busy park in the pending buffer; the latest one wins.
    if (state != IDLE && set_i) begin
      pend_nxt = 1'b1;
      pbuf_nxt = codes_i;
    end

    case (state)
      IDLE: begin
        if (set_i) begin
          state_nxt = SHIFT_LO;
          shreg_nxt = codes_i;
          cnt_nxt   = H_LOAD;
          bit_nxt   = BIT_LOAD;
        end
      end
      SHIFT_LO: begin
        if (cnt == '0) begin
          state_nxt = SHIFT_HI;
          cnt_nxt   = H_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt == '0) begin
          cnt_nxt = H_LOAD;
          if (bit_cnt == '0) begin
            state_nxt = TAIL;
          end else begin
            state_nxt = SHIFT_LO;
            shreg_nxt = shreg << 1;
            bit_nxt   = bit_cnt - BIT_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          // A request sampled on this very edge is as good as a pending one.
          if (pend || set_i) begin
            state_nxt = SHIFT_LO;
            shreg_nxt = set_i ? codes_i : pbuf;
            cnt_nxt   = H_LOAD;
            bit_nxt   = BIT_LOAD;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    in_frame = (state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI) || (state_nxt == TAIL);
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge sck) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      pbuf    <= '0;
      pend    <= 1'b0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sclk_o  <= 1'b0;
      cs_n    <= 1'b1;
      miso    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      pbuf    <= pbuf_nxt;
      pend    <= pend_nxt;
      ready_o <= (state_nxt == IDLE) && !pend_nxt;
      busy_o  <= (state_nxt != IDLE);
      done_o  <= (state_nxt == GAP) && (cnt_nxt == '0);
      sclk_o  <= (state_nxt == SHIFT_HI);
      cs_n    <= !in_frame;
      miso    <= in_frame && shreg_nxt[NB-1];
    end
  end

endmodule

// File: doc/pga_chain_interface.md
Name: pga_chain_interface

Overview:
- Parametrised successor to the single-PGA serial loader.
- Drives N_CH daisy-chained programmable-gain amplifiers from one chip select, with a generated serial clock at a programmable divided rate.
- Accepts one gain code per channel and shifts all codes out in a single cs_n frame.
- Adds a one-deep pending request, a frame-done pulse and a guaranteed cs_n idle gap; sits between gain-control logic and the PGA SPI pins.

Parameters:
- CODE_W, 8: bits per channel gain code.
- N_CH, 2: number of daisy-chained PGAs (>=1).
- DIV_HALF, 1: sck cycles per serial-clock half-period (>=1).
- CS_GAP, 2: minimum sck cycles cs_n stays high between frames (>=1).

Ports:
- sck, in, 1: block clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- codes_i, in, N_CH*CODE_W: channel k code at bits [k*CODE_W +: CODE_W].
- set_i, in, 1: request to load codes_i, sampled every cycle.
- ready_o, out, 1: idle, no frame or pending request outstanding.
- busy_o, out, 1: frame in progress (cs_n low or inside the gap).
- done_o, out, 1: one-cycle pulse at the end of each frame's gap.
- sclk_o, out, 1: serial clock to the PGAs, idle low (mode 0).
- cs_n, out, 1: active-low chip select shared by the chain.
- miso, out, 1: serial data to the first PGA in the chain; changes only while sclk_o is low.

Behaviour:
- Reset (rst=1 at a rising edge) takes effect on that edge and sets: ready_o=1, busy_o=0, done_o=0, sclk_o=0, cs_n=1, miso=0.
- Reset also clears the state to IDLE and drops the pending flag.
- Reset mid-frame aborts immediately with no partial cs_n rising glitch beyond the abort edge.
- Definitions: NB = N_CH*CODE_W. Frame word F is channel N_CH-1 code first, channel 0 code last, MSB first within each code.
- States: IDLE, SHIFT_LO, SHIFT_HI, TAIL, GAP.
- IDLE -> SHIFT_LO: set_i=1 in IDLE latches codes_i into the shift register. The next cycle is frame cycle 0: cs_n=0, miso=F[NB-1], ready_o=0, busy_o=1.
- Bit i (i=0..NB-1) timing:
  - sclk_o low for cycles [2iH, 2iH+H-1], with H=DIV_HALF.
  - sclk_o high for cycles [2iH+H, 2iH+2H-1].
  - miso updates to bit i only at cycle 2iH and is stable through the high phase.
- SHIFT_LO -> SHIFT_HI after H cycles. SHIFT_HI -> SHIFT_LO (next bit) after H cycles, or -> TAIL after bit NB-1.
- TAIL: cycles [2NB*H, 2NB*H+H-1]; sclk_o=0, cs_n=0, miso holds the last bit.
- GAP: cs_n=1, miso=0, sclk_o=0 for CS_GAP cycles.
  - done_o=1 on the final GAP cycle.
  - Then IDLE with ready_o=1 and busy_o=0, i.e. cycle 2NB*H+H+CS_GAP.
- Pending request:
  - set_i=1 while busy latches codes_i into a pending buffer and sets pending; a later set_i overwrites the buffer (last writer wins).
  - At the end of GAP with pending=1: skip IDLE, load the pending buffer, clear pending, and start a new frame next cycle.
  - ready_o stays 0 throughout; done_o still pulses for the first frame.
- set_i in the same cycle as the last GAP cycle counts as pending, so the next frame starts immediately after.
- codes_i changes during a frame do not affect the frame in flight.
- ready_o = IDLE and not pending. busy_o = not IDLE.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
- Defaults (N_CH=2, CODE_W=8, H=1, CS_GAP=2), codes_i=16'h8F3C (ch1=8F, ch0=3C), one set_i pulse:
  - cs_n low for 33 cycles.
  - 16 sclk_o rising edges; bits sampled at the rising edges equal 16'h8F3C.
  - done_o high on the cycle before ready_o returns; ready_o=1 at frame cycle 35.
- H=3, N_CH=1, code 8'hA5: sclk_o high/low phases are each exactly 3 cycles.
  - miso is stable across each high phase; 8 edges capture 8'hA5.
  - Total cs_n low = 51 cycles.
- set_i with 16'h1234 during frame 1, then 16'h5678 a few cycles later:
  - Frame 2 immediately follows the CS_GAP gap and carries 16'h5678.
  - ready_o stays 0 across both frames.
  - Two done_o pulses.
- rst asserted at frame cycle 10: the next edge gives cs_n=1, sclk_o=0, miso=0, ready_o=1, with no done_o.
  - A new set_i afterwards produces a complete correct frame.
- Back-to-back: set_i held high continuously with constant codes.
  - Frames repeat with exactly CS_GAP cycles of cs_n high between them.
  - cs_n never goes low with sclk_o high.
- Post-reset idle: rst then 20 idle cycles gives ready_o=1, busy_o=0, and cs_n/sclk_o/miso constant at 1/0/0.
